instr_control_unit: RTL and testbench

//  Fetch/execute sequencer directly upstream of the regfile+ALU datapath. It holds
//  the program counter and the instruction register, decodes a 32-bit instruction
//  and drives the datapath control word (W, SA, SB, DA, FS, K, K_SEL, C0, EN_ALU,
//  EN_B). It also latches the datapath Status flags so that conditional branches can use them.

---
 rtl/instr_control_unit_if.sv | 35 +++
 rtl/instr_control_unit.sv | 170 +++++++++++++++++
 tb/tb_instr_control_unit.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_control_unit_if.sv
// Fetch and datapath-control bundle for instr_control_unit.
// master: the control unit. slave: the memory/datapath side (or a bench).
interface instr_control_unit_if #(
    parameter int PC_W = 64
);
    logic [31:0]     instr;
    logic            instr_valid;
    logic [3:0]      Status;
    logic [PC_W-1:0] pc;
    logic            instr_req;
    logic            W;
    logic            K_SEL;
    logic            C0;
    logic            EN_ALU;
    logic            EN_B;
    logic [4:0]      SA;
    logic [4:0]      SB;
    logic [4:0]      DA;
    logic [4:0]      FS;
    logic [63:0]     K;
    logic            halted;
    logic            illegal;

    modport master (
        input  instr, instr_valid, Status,
        output pc, instr_req, W, K_SEL, C0, EN_ALU, EN_B, SA, SB, DA, FS, K,
               halted, illegal
    );

    modport slave (
        output instr, instr_valid, Status,
        input  pc, instr_req, W, K_SEL, C0, EN_ALU, EN_B, SA, SB, DA, FS, K,
               halted, illegal
    );
endinterface

// File: rtl/instr_control_unit.sv
// Fetch/execute sequencer: holds PC and IR, decodes the instruction and drives
// the regfile/ALU control word. Two cycles per instruction (FETCH, EXECUTE);
// HALT is absorbing until reset.
// Optional feature macro: CU_COND_BRANCH_EN -- adds the flag register and the
// BZ/BNZ conditional branches; without it those opcodes decode as illegal.
module instr_control_unit #(
    parameter int PC_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_control_unit_if.master bus
);
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01010;
    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_OR  = 5'b00100;

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_AND  = 6'h03;
    localparam logic [5:0] OP_ORR  = 6'h04;
    localparam logic [5:0] OP_MOV  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SUBI = 6'h09;
    localparam logic [5:0] OP_ANDI = 6'h0A;
    localparam logic [5:0] OP_ORRI = 6'h0B;
    localparam logic [5:0] OP_MOVI = 6'h0C;
    localparam logic [5:0] OP_B    = 6'h10;
    localparam logic [5:0] OP_BZ   = 6'h11;
    localparam logic [5:0] OP_BNZ  = 6'h12;
    localparam logic [5:0] OP_HALT = 6'h3F;

    logic [1:0]      state;
    logic [PC_W-1:0] pc_q;
    logic [31:0]     ir;
    logic [5:0]      op;
    logic            alu_op;
    logic            is_halt;
    logic            take_br;
    logic [PC_W-1:0] br_off;
    logic [PC_W-1:0] pc_next;

    assign op     = ir[31:26];
    // imm26 is a word offset: sign-extend and scale to bytes
    assign br_off = {{(PC_W-28){ir[25]}}, ir[25:0], 2'b00};
    // modulo-2^PC_W arithmetic, wrap is intentional
    assign pc_next = take_br ? (pc_q + br_off) : (pc_q + PC_W'(4));

    // instr_req is held low while reset is asserted even though state is FETCH
    assign bus.pc        = pc_q;
    assign bus.instr_req = (state == S_FETCH) && rst;
    assign bus.halted    = (state == S_HALT);

`ifdef CU_COND_BRANCH_EN
    logic [3:0] flags;  // {V,C,N,Z}

    // capture datapath status on the execute edge of ALU-writing ops only
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            flags <= 4'd0;
        else if (state == S_EXEC && alu_op)
            flags <= bus.Status;
    end
`else
    logic unused_status;
    assign unused_status = ^{bus.Status, alu_op};
`endif

    // decode IR into the control word; idle/reset word outside EXECUTE
    always_comb begin
        bus.W       = 1'b0;
        bus.EN_ALU  = 1'b0;
        bus.EN_B    = 1'b0;
        bus.K_SEL   = 1'b0;
        bus.C0      = 1'b0;
        bus.SA      = 5'd31;
        bus.SB      = 5'd31;
        bus.DA      = 5'd31;
        bus.FS      = FS_ADD;
        bus.K       = 64'd0;
        bus.illegal = 1'b0;
        alu_op      = 1'b0;
        is_halt     = 1'b0;
        take_br     = 1'b0;
        if (state == S_EXEC) begin
            case (op)
                OP_NOP: ;
                OP_ADD, OP_SUB, OP_AND, OP_ORR,
                OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI: begin
                    bus.W      = 1'b1;
                    bus.EN_ALU = 1'b1;
                    alu_op     = 1'b1;
                    bus.DA     = ir[25:21];
                    bus.SA     = ir[20:16];
                    // op[3] separates immediate forms from register forms
                    if (op[3]) begin
                        bus.K_SEL = 1'b1;
                        bus.K     = {48'd0, ir[15:0]};
                    end else begin
                        bus.SB = ir[15:11];
                    end
                    case (op)
                        OP_ADD, OP_ADDI: bus.FS = FS_ADD;
                        OP_SUB, OP_SUBI: begin
                            bus.FS = FS_SUB;
                            bus.C0 = 1'b1;
                        end
                        OP_AND, OP_ANDI: bus.FS = FS_AND;
                        default:         bus.FS = FS_OR;
                    endcase
                end
                OP_MOV: begin
                    bus.W    = 1'b1;
                    bus.EN_B = 1'b1;
                    bus.DA   = ir[25:21];
                    bus.SB   = ir[15:11];
                end
                OP_MOVI: begin
                    // R31 reads as zero, so 0 + K loads the immediate
                    bus.W      = 1'b1;
                    bus.EN_ALU = 1'b1;
                    alu_op     = 1'b1;
                    bus.K_SEL  = 1'b1;
                    bus.DA     = ir[25:21];
                    bus.K      = {48'd0, ir[15:0]};
                end
                OP_B: take_br = 1'b1;
`ifdef CU_COND_BRANCH_EN
                OP_BZ:  take_br = flags[0];
                OP_BNZ: take_br = ~flags[0];
`endif
                OP_HALT: is_halt = 1'b1;
                default: bus.illegal = 1'b1;
            endcase
        end
    end

    // FETCH/EXECUTE/HALT sequencing, PC and IR update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_FETCH;
            pc_q  <= '0;
            ir    <= 32'd0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (bus.instr_valid) begin
                        ir    <= bus.instr;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_halt) begin
                        state <= S_HALT;
                    end else begin
                        pc_q  <= pc_next;
                        state <= S_FETCH;
                    end
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_control_unit.sv
// Self-checking bench for instr_control_unit. Each issued instruction pushes its
// expected control word and PC onto a scoreboard; the entry is popped and
// compared during that instruction's EXECUTE cycle.
module tb_instr_control_unit;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01010;
    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_OR  = 5'b00100;
    localparam logic [25:0] IMM_M2 = 26'h3FFFFFE;  // -2 words
    localparam logic [25:0] IMM_M1 = 26'h3FFFFFF;  // -1 word

    logic clk = 1'b0;
    logic rst = 1'b0;

    instr_control_unit_if #(.PC_W(64)) bus();
    instr_control_unit #(.PC_W(64)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic        W;
        logic [4:0]  SA;
        logic [4:0]  SB;
        logic [4:0]  DA;
        logic [4:0]  FS;
        logic [63:0] K;
        logic        K_SEL;
        logic        C0;
        logic        EN_ALU;
        logic        EN_B;
        logic        illegal;
    } cw_t;

    typedef struct {
        cw_t         cw;
        cw_t         mask;
        logic [63:0] pc;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] mpc;
    bit          tie_valid = 1'b0;
    cw_t         RST, FULL, NOSB, RMSK, CTRL, MOVM;

    function automatic cw_t mk(input logic w, input logic [4:0] sa, input logic [4:0] sb_,
                               input logic [4:0] da, input logic [4:0] fs, input logic [63:0] k,
                               input logic ks, input logic c0, input logic ea, input logic eb,
                               input logic il);
        cw_t c;
        c.W = w; c.SA = sa; c.SB = sb_; c.DA = da; c.FS = fs; c.K = k;
        c.K_SEL = ks; c.C0 = c0; c.EN_ALU = ea; c.EN_B = eb; c.illegal = il;
        return c;
    endfunction

    function automatic cw_t obs_cw();
        return mk(bus.W, bus.SA, bus.SB, bus.DA, bus.FS, bus.K, bus.K_SEL, bus.C0,
                  bus.EN_ALU, bus.EN_B, bus.illegal);
    endfunction

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] da,
                                          input logic [4:0] sa, input logic [4:0] sb_);
        return {op, da, sa, sb_, 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] da,
                                          input logic [4:0] sa, input logic [15:0] imm);
        return {op, da, sa, imm};
    endfunction

    function automatic logic [31:0] enc_b(input logic [5:0] op, input logic [25:0] imm);
        return {op, imm};
    endfunction

    // wait (bounded) for a fetch request, present one instruction, return in EXECUTE
    task automatic issue(input string name, input logic [31:0] ins, input cw_t cw,
                         input cw_t mask, input logic [3:0] st);
        exp_t e;
        int t;
        e.cw = cw; e.mask = mask; e.pc = mpc; e.name = name;
        sb.push_back(e);
        t = 0;
        while (bus.instr_req !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (bus.instr_req !== 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL %s fetch_timeout: instr_req=%b required 1", name, bus.instr_req);
        end
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        bus.Status      = st;
        @(negedge clk);
        if (!tie_valid) bus.instr_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        mpc = 64'd0;
        #1;
    endtask

    task automatic test_reset();
        cw_t o;
        bus.instr = 32'd0; bus.instr_valid = 1'b0; bus.Status = 4'd0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        o = obs_cw(); n_cmp++;
        if ((o ^ RST) !== '0) begin
            n_err++; $display("FAIL reset_cw: got %h required %h", o, RST);
        end
        n_cmp++;
        if ({bus.pc, bus.instr_req, bus.halted} !== {64'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: pc=%h req=%b halted=%b required 0/0/0",
                     bus.pc, bus.instr_req, bus.halted);
        end
        rst = 1'b1; mpc = 64'd0;
        #1; n_cmp++;
        if (bus.instr_req !== 1'b1) begin
            n_err++; $display("FAIL reset_release_req: got %b required 1", bus.instr_req);
        end
    endtask

    task automatic test_movi();
        exp_t e; cw_t o; time tx[2];
        tie_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            issue("movi", enc_i(6'h0C, 5'd0, 5'd0, 16'hFFFF),
                  mk(1, 31, 0, 0, FS_ADD, 64'hFFFF, 1, 0, 1, 0, 0), NOSB, 4'd0);
            tx[i] = $time;
            e = sb.pop_front(); o = obs_cw(); n_cmp++;
            if ((((o ^ e.cw) & e.mask) !== '0) || (bus.pc !== e.pc)) begin
                n_err++;
                $display("FAIL %s: got cw=%h pc=%h required cw=%h mask=%h pc=%h",
                         e.name, o, bus.pc, e.cw, e.mask, e.pc);
            end
            mpc = mpc + 64'd4;
        end
        tie_valid = 1'b0; bus.instr_valid = 1'b0;
        n_cmp++;
        if (tx[1] - tx[0] != 20) begin
            n_err++; $display("FAIL movi_rate: got %0t per instr required 20", tx[1] - tx[0]);
        end
    endtask

    task automatic test_alu_ops();
        logic [31:0] ins[$]; cw_t cws[$]; cw_t msk[$];
        exp_t e; cw_t o;
        ins.push_back(enc_r(6'h01, 2, 3, 4)); cws.push_back(mk(1, 3, 4, 2, FS_ADD, 0, 0, 0, 1, 0, 0)); msk.push_back(RMSK);
        ins.push_back(enc_r(6'h02, 2, 3, 4)); cws.push_back(mk(1, 3, 4, 2, FS_SUB, 0, 0, 1, 1, 0, 0)); msk.push_back(RMSK);
        ins.push_back(enc_r(6'h03, 9, 10, 11)); cws.push_back(mk(1, 10, 11, 9, FS_AND, 0, 0, 0, 1, 0, 0)); msk.push_back(RMSK);
        ins.push_back(enc_r(6'h04, 30, 29, 28)); cws.push_back(mk(1, 29, 28, 30, FS_OR, 0, 0, 0, 1, 0, 0)); msk.push_back(RMSK);
        ins.push_back(enc_i(6'h08, 6, 7, 16'h8001)); cws.push_back(mk(1, 7, 0, 6, FS_ADD, 64'h8001, 1, 0, 1, 0, 0)); msk.push_back(NOSB);
        ins.push_back(enc_i(6'h09, 4, 1, 16'h0001)); cws.push_back(mk(1, 1, 0, 4, FS_SUB, 64'h1, 1, 1, 1, 0, 0)); msk.push_back(NOSB);
        ins.push_back(enc_i(6'h0A, 12, 13, 16'h00F0)); cws.push_back(mk(1, 13, 0, 12, FS_AND, 64'hF0, 1, 0, 1, 0, 0)); msk.push_back(NOSB);
        ins.push_back(enc_i(6'h0B, 14, 15, 16'hFFFF)); cws.push_back(mk(1, 15, 0, 14, FS_OR, 64'hFFFF, 1, 0, 1, 0, 0)); msk.push_back(NOSB);
        for (int i = 0; i < ins.size(); i++) begin
            issue($sformatf("alu_op%0d", i), ins[i], cws[i], msk[i], 4'(i));
            e = sb.pop_front(); o = obs_cw(); n_cmp++;
            if ((((o ^ e.cw) & e.mask) !== '0) || (bus.pc !== e.pc)) begin
                n_err++;
                $display("FAIL %s: got cw=%h pc=%h required cw=%h mask=%h pc=%h",
                         e.name, o, bus.pc, e.cw, e.mask, e.pc);
            end
            mpc = mpc + 64'd4;
        end
    endtask

    // MOV must not touch flags: Z set by ADDI survives a MOV with Status.Z=0
    task automatic test_mov_flags();
        logic [31:0] ins[$]; cw_t cws[$]; cw_t msk[$]; logic [3:0] sts[$]; longint dl[$];
        exp_t e; cw_t o;
        ins.push_back(enc_i(6'h08, 1, 31, 0)); cws.push_back(mk(1, 31, 0, 1, FS_ADD, 0, 1, 0, 1, 0, 0));
        msk.push_back(NOSB); sts.push_back(4'b0001); dl.push_back(4);
        ins.push_back(enc_r(6'h05, 5, 0, 1)); cws.push_back(mk(1, 0, 1, 5, FS_ADD, 0, 0, 0, 0, 1, 0));
        msk.push_back(MOVM); sts.push_back(4'b0000); dl.push_back(4);
`ifdef CU_COND_BRANCH_EN
        ins.push_back(enc_b(6'h11, IMM_M2)); cws.push_back(mk(0, 31, 31, 31, FS_ADD, 0, 0, 0, 0, 0, 0));
        msk.push_back(CTRL); sts.push_back(4'b0000); dl.push_back(-8);
`else
        ins.push_back(enc_b(6'h11, IMM_M2)); cws.push_back(mk(0, 31, 31, 31, FS_ADD, 0, 0, 0, 0, 0, 1));
        msk.push_back(CTRL); sts.push_back(4'b0000); dl.push_back(4);
`endif
        ins.push_back(enc_i(6'h08, 1, 31, 0)); cws.push_back(mk(1, 31, 0, 1, FS_ADD, 0, 1, 0, 1, 0, 0));
        msk.push_back(NOSB); sts.push_back(4'b1110); dl.push_back(4);
`ifdef CU_COND_BRANCH_EN
        ins.push_back(enc_b(6'h11, IMM_M2)); cws.push_back(mk(0, 31, 31, 31, FS_ADD, 0, 0, 0, 0, 0, 0));
`else
        ins.push_back(enc_b(6'h11, IMM_M2)); cws.push_back(mk(0, 31, 31, 31, FS_ADD, 0, 0, 0, 0, 0, 1));
`endif
        msk.push_back(CTRL); sts.push_back(4'b0001); dl.push_back(4);
        ins.push_back(enc_r(6'h00, 0, 0, 0)); cws.push_back(mk(0, 31, 31, 31, FS_ADD, 0, 0, 0, 0, 0, 0));
        msk.push_back(CTRL); sts.push_back(4'b0000); dl.push_back(4);
        for (int i = 0; i < ins.size(); i++) begin
            issue($sformatf("mov_flags%0d", i), ins[i], cws[i], msk[i], sts[i]);
            e = sb.pop_front(); o = obs_cw(); n_cmp++;
            if ((((o ^ e.cw) & e.mask) !== '0) || (bus.pc !== e.pc)) begin
                n_err++;
                $display("FAIL %s: got cw=%h pc=%h required cw=%h mask=%h pc=%h",
                         e.name, o, bus.pc, e.cw, e.mask, e.pc);
            end
            mpc = mpc + 64'(dl[i]);
        end
    endtask

    // BZ/BNZ around pc=16, then unconditional zero-offset self loop
    task automatic test_branch();
        logic [31:0] ins[$]; cw_t cws[$]; logic [3:0] sts[$]; longint dl[$];
        logic [31:0] nop; cw_t nopw; exp_t e; cw_t o;
        nop  = enc_r(6'h00, 0, 0, 0);
        nopw = mk(0, 31, 31, 31, FS_ADD, 0, 0, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            ins.push_back(nop); cws.push_back(nopw); sts.push_back(4'd0); dl.push_back(4);
        end
        ins.push_back(enc_i(6'h08, 3, 31, 16'd0)); cws.push_back(mk(1, 31, 0, 3, FS_ADD, 0, 1, 0, 1, 0, 0));
        sts.push_back(4'b0001); dl.push_back(4);
`ifdef CU_COND_BRANCH_EN
        ins.push_back(enc_b(6'h11, IMM_M2)); cws.push_back(nopw); sts.push_back(4'd0); dl.push_back(-8);
        ins.push_back(nop); cws.push_back(nopw); sts.push_back(4'd0); dl.push_back(4);
        ins.push_back(nop); cws.push_back(nopw); sts.push_back(4'd0); dl.push_back(4);
        ins.push_back(enc_b(6'h12, IMM_M2)); cws.push_back(nopw); sts.push_back(4'd0); dl.push_back(4);
`else
        ins.push_back(enc_b(6'h11, IMM_M2)); cws.push_back(mk(0, 31, 31, 31, FS_ADD, 0, 0, 0, 0, 0, 1));
        sts.push_back(4'd0); dl.push_back(4);
        ins.push_back(enc_b(6'h12, IMM_M2)); cws.push_back(mk(0, 31, 31, 31, FS_ADD, 0, 0, 0, 0, 0, 1));
        sts.push_back(4'd0); dl.push_back(4);
`endif
        ins.push_back(enc_b(6'h10, 26'd0)); cws.push_back(nopw); sts.push_back(4'd0); dl.push_back(0);
        ins.push_back(enc_b(6'h10, 26'd0)); cws.push_back(nopw); sts.push_back(4'd0); dl.push_back(0);
        ins.push_back(nop); cws.push_back(nopw); sts.push_back(4'd0); dl.push_back(4);
        for (int i = 0; i < ins.size(); i++) begin
            issue($sformatf("branch%0d", i), ins[i], cws[i], (i == 3) ? NOSB : CTRL, sts[i]);
            e = sb.pop_front(); o = obs_cw(); n_cmp++;
            if ((((o ^ e.cw) & e.mask) !== '0) || (bus.pc !== e.pc)) begin
                n_err++;
                $display("FAIL %s: got cw=%h pc=%h required cw=%h mask=%h pc=%h",
                         e.name, o, bus.pc, e.cw, e.mask, e.pc);
            end
            mpc = mpc + 64'(dl[i]);
        end
    endtask

    // backward branch from 0 wraps to the top of the address space and back
    task automatic test_wrap();
        logic [31:0] ins[3]; logic [63:0] pcs[3]; exp_t e; cw_t o;
        do_reset();
        ins[0] = enc_b(6'h10, IMM_M1); pcs[0] = 64'd0;
        ins[1] = enc_r(6'h00, 0, 0, 0); pcs[1] = 64'hFFFF_FFFF_FFFF_FFFC;
        ins[2] = enc_r(6'h00, 0, 0, 0); pcs[2] = 64'd0;
        for (int i = 0; i < 3; i++) begin
            mpc = pcs[i];
            issue($sformatf("wrap%0d", i), ins[i], mk(0, 31, 31, 31, FS_ADD, 0, 0, 0, 0, 0, 0), CTRL, 4'd0);
            e = sb.pop_front(); o = obs_cw(); n_cmp++;
            if ((((o ^ e.cw) & e.mask) !== '0) || (bus.pc !== e.pc)) begin
                n_err++;
                $display("FAIL %s: got cw=%h pc=%h required cw=%h mask=%h pc=%h",
                         e.name, o, bus.pc, e.cw, e.mask, e.pc);
            end
        end
        mpc = 64'd4;
    endtask

    task automatic test_illegal();
        logic [5:0] ops[3]; exp_t e; cw_t o;
        ops[0] = 6'h20; ops[1] = 6'h06; ops[2] = 6'h3E;
        for (int i = 0; i < 3; i++) begin
            issue($sformatf("illegal_op%0h", ops[i]), {ops[i], 26'h1234567},
                  mk(0, 31, 31, 31, FS_ADD, 0, 0, 0, 0, 0, 1), CTRL, 4'd0);
            e = sb.pop_front(); o = obs_cw(); n_cmp++;
            if ((((o ^ e.cw) & e.mask) !== '0) || (bus.pc !== e.pc)) begin
                n_err++;
                $display("FAIL %s: got cw=%h pc=%h required cw=%h mask=%h pc=%h",
                         e.name, o, bus.pc, e.cw, e.mask, e.pc);
            end
            mpc = mpc + 64'd4;
            @(negedge clk); n_cmp++;
            if (bus.illegal !== 1'b0 || bus.pc !== mpc) begin
                n_err++;
                $display("FAIL illegal_pulse: illegal=%b pc=%h required 0 pc=%h", bus.illegal, bus.pc, mpc);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e; cw_t o;
        issue("addi_pre_reset", enc_i(6'h08, 7, 1, 16'd5),
              mk(1, 1, 0, 7, FS_ADD, 64'd5, 1, 0, 1, 0, 0), NOSB, 4'd0);
        e = sb.pop_front(); o = obs_cw(); n_cmp++;
        if ((((o ^ e.cw) & e.mask) !== '0) || (bus.pc !== e.pc)) begin
            n_err++;
            $display("FAIL %s: got cw=%h pc=%h required cw=%h mask=%h pc=%h",
                     e.name, o, bus.pc, e.cw, e.mask, e.pc);
        end
        rst = 1'b0;
        #1; o = obs_cw(); n_cmp++;
        if ((o ^ RST) !== '0 || bus.pc !== 64'd0 || bus.instr_req !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: cw=%h pc=%h req=%b required cw=%h pc=0 req=0", o, bus.pc, bus.instr_req, RST);
        end
        @(negedge clk);
        rst = 1'b1; mpc = 64'd0;
        #1; n_cmp++;
        if (bus.instr_req !== 1'b1 || bus.halted !== 1'b0 || bus.pc !== 64'd0) begin
            n_err++;
            $display("FAIL mid_reset_release: req=%b halted=%b pc=%h required 1/0/0", bus.instr_req, bus.halted, bus.pc);
        end
        issue("nop_after_reset", enc_r(6'h00, 0, 0, 0), mk(0, 31, 31, 31, FS_ADD, 0, 0, 0, 0, 0, 0), CTRL, 4'd0);
        e = sb.pop_front(); o = obs_cw(); n_cmp++;
        if ((((o ^ e.cw) & e.mask) !== '0) || (bus.pc !== e.pc)) begin
            n_err++;
            $display("FAIL %s: got cw=%h pc=%h required cw=%h mask=%h pc=%h",
                     e.name, o, bus.pc, e.cw, e.mask, e.pc);
        end
        mpc = mpc + 64'd4;
    endtask

    task automatic test_halt();
        exp_t e; cw_t o; logic [63:0] frozen;
        issue("halt", enc_b(6'h3F, 26'd0), mk(0, 31, 31, 31, FS_ADD, 0, 0, 0, 0, 0, 0), CTRL, 4'd0);
        e = sb.pop_front(); o = obs_cw(); n_cmp++;
        if ((((o ^ e.cw) & e.mask) !== '0) || (bus.pc !== e.pc)) begin
            n_err++;
            $display("FAIL %s: got cw=%h pc=%h required cw=%h mask=%h pc=%h",
                     e.name, o, bus.pc, e.cw, e.mask, e.pc);
        end
        frozen = mpc;
        bus.instr = enc_r(6'h01, 1, 2, 3);
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); n_cmp++;
            if ({bus.halted, bus.instr_req, bus.W, bus.pc} !== {1'b1, 1'b0, 1'b0, frozen}) begin
                n_err++;
                $display("FAIL halt_cycle%0d: halted=%b req=%b W=%b pc=%h required 1/0/0 pc=%h",
                         i, bus.halted, bus.instr_req, bus.W, bus.pc, frozen);
            end
        end
        bus.instr_valid = 1'b0;
        do_reset();
        n_cmp++;
        if ({bus.halted, bus.instr_req, bus.pc} !== {1'b0, 1'b1, 64'd0}) begin
            n_err++;
            $display("FAIL halt_exit: halted=%b req=%b pc=%h required 0/1/0", bus.halted, bus.instr_req, bus.pc);
        end
        issue("add_after_halt", enc_r(6'h01, 1, 2, 3), mk(1, 2, 3, 1, FS_ADD, 0, 0, 0, 1, 0, 0), RMSK, 4'd0);
        e = sb.pop_front(); o = obs_cw(); n_cmp++;
        if ((((o ^ e.cw) & e.mask) !== '0) || (bus.pc !== e.pc)) begin
            n_err++;
            $display("FAIL %s: got cw=%h pc=%h required cw=%h mask=%h pc=%h",
                     e.name, o, bus.pc, e.cw, e.mask, e.pc);
        end
    endtask

    initial begin
        RST  = mk(0, 31, 31, 31, FS_ADD, 64'd0, 0, 0, 0, 0, 0);
        FULL = mk(1, 5'h1F, 5'h1F, 5'h1F, 5'h1F, '1, 1, 1, 1, 1, 1);
        NOSB = mk(1, 5'h1F, 5'h00, 5'h1F, 5'h1F, '1, 1, 1, 1, 1, 1);
        RMSK = mk(1, 5'h1F, 5'h1F, 5'h1F, 5'h1F, '0, 1, 1, 1, 1, 1);
        CTRL = mk(1, 5'h00, 5'h00, 5'h00, 5'h00, '0, 0, 0, 1, 1, 1);
        MOVM = mk(1, 5'h00, 5'h1F, 5'h1F, 5'h00, '0, 0, 0, 1, 1, 1);
        test_reset();
        test_movi();
        test_alu_ops();
        test_mov_flags();
        test_branch();
        test_wrap();
        test_illegal();
        test_reset_mid();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
